fir_inverse_filter: RTL and testbench

- Recursive inverse (decoder) of the 6-tap transposed FIR datapath. Given the FIR output stream b[n] and the same coefficients, it reconstructs the original 16-bit input a[n].
- Requires c0 = 2^SHIFT. Then a[n] = (b[n] - sum_{k=1..5} c_k*a[n-k]) >> SHIFT.
- Time-multiplexed: one shared 16x14 multiplier; valid/ready handshakes on both input and output.
- Sits at the receive end of a filtered link, after the FIR's 26-bit output.

---
 rtl/fir_inverse_filter.sv | 177 +++++++++++++++++
 tb/tb_fir_inverse_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_inverse_filter.sv
// Recursive decoder for the 6-tap transposed FIR: a[n] = (b[n] - sum c_k*a[n-k]) >>> SHIFT, one shared multiplier.
// Optional saturation-event counter enabled by defining FIR_INV_SAT_CNT_EN.
module fir_inverse_filter #(
  parameter int SHIFT = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [25:0] in_data,
  input  logic signed [13:0] c1,
  input  logic signed [13:0] c2,
  input  logic signed [13:0] c3,
  input  logic signed [13:0] c4,
  input  logic signed [13:0] c5,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               out_sat,
  output logic [15:0]        sat_count
);

  localparam int ACC_W = 34;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]              k_q, k_d;
  logic [4:0][15:0]        h_q, h_d;
  logic [4:0][13:0]        c_q, c_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [15:0]      mul_h;
  logic signed [13:0]      mul_c;
  logic signed [29:0]      prod;
  logic signed [ACC_W-1:0] acc_mac;
  logic signed [ACC_W-1:0] acc_shr;
  logic [15:0]             res_data;
  logic                    res_sat;

  // Tap select for the shared 16x14 multiplier; k is 1..5 while in MAC.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mul_h = '0;
    mul_c = '0;
    case (k_q)
      3'd1: begin mul_h = h_q[0]; mul_c = c_q[0]; end
      3'd2: begin mul_h = h_q[1]; mul_c = c_q[1]; end
      3'd3: begin mul_h = h_q[2]; mul_c = c_q[2]; end
      3'd4: begin mul_h = h_q[3]; mul_c = c_q[3]; end
      3'd5: begin mul_h = h_q[4]; mul_c = c_q[4]; end
      default: ;
    endcase
  end

  assign prod    = 30'(mul_h) * 30'(mul_c);
  assign acc_mac = acc_q - ACC_W'(prod);
  assign acc_shr = acc_mac >>> SHIFT;

  // Clamp the floored quotient to the 16-bit signed output range.
  always_comb begin
    res_data = acc_shr[15:0];
    res_sat  = 1'b0;
    if (acc_shr > 34'sd32767) begin
      res_data = 16'h7fff;
      res_sat  = 1'b1;
    end else if (acc_shr < -34'sd32768) begin
      res_data = 16'h8000;
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    h_d         = h_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d      = ACC_W'(in_data);
          c_d        = {c5, c4, c3, c2, c1};
          k_d        = 3'd1;
          in_ready_d = 1'b0;
          state_d    = MAC;
        end
      end
      MAC: begin
        acc_d = acc_mac;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd5) begin
          k_d         = 3'd0;
          out_data_d  = res_data;
          out_sat_d   = res_sat;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        // History holds what was actually emitted, i.e. the clamped value.
        if (out_ready) begin
          h_d         = {h_q[3:0], out_data_q};
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: history and coefficient latches are plain flops (not RAM), so they are cleared by reset.
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      h_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      h_q         <= h_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

`ifdef FIR_INV_SAT_CNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Counts delivered saturated samples; sticks at full scale.
  always_comb begin
    sat_count_d = sat_count_q;
    if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hffff))
      sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_count_q <= '0;
    else       sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Self-checking bench for fir_inverse_filter: directed cases plus a randomized FIR round trip
// compared against an arithmetic reference decoder.
module tb_fir_inverse_filter;

  localparam int SHIFT = 12;
`ifdef FIR_INV_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef int coef_t [5];

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [25:0] in_data;
  logic signed [13:0] c1, c2, c3, c4, c5;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic [15:0]        sat_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference decoder state: emitted-sample history and latched coefficients.
  longint mh [5];
  longint mc [5];
  longint m_sat_cnt;

  fir_inverse_filter #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .c5        (c5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) begin
      mh[i] = 0;
      mc[i] = 0;
    end
    m_sat_cnt = 0;
  endfunction

  function automatic void model_decode(input longint b, output longint d, output longint s);
    longint acc;
    acc = b;
    for (int i = 0; i < 5; i++) acc -= mc[i] * mh[i];
    d = acc >>> SHIFT;
    s = 0;
    if (d > 32767) begin d = 32767; s = 1; end
    else if (d < -32768) begin d = -32768; s = 1; end
  endfunction

  function automatic void model_emit(input longint d, input longint s);
    for (int i = 4; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = d;
    if (SAT_EN && s != 0 && m_sat_cnt < 65535) m_sat_cnt++;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coefs(input coef_t cf);
    c1 = 14'(cf[0]);
    c2 = 14'(cf[1]);
    c3 = 14'(cf[2]);
    c4 = 14'(cf[3]);
    c5 = 14'(cf[4]);
  endtask

  // One full transaction: offer b, check latency/result, stall the output, then hand it off.
  task automatic do_sample(input longint b, input coef_t cf, input int ready_delay,
                           input bit scramble, input bit early_ready, output longint got);
    int     n;
    int     lat;
    longint exp_d, exp_s;
    set_coefs(cf);
    in_data  = 26'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) mc[i] = cf[i];
    model_decode(b, exp_d, exp_s);
    if (scramble) begin
      c1 = 14'($urandom); c2 = 14'($urandom); c3 = 14'($urandom);
      c4 = 14'($urandom); c5 = 14'($urandom);
    end
    out_ready = early_ready;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 5);
    check("out_data", out_data, exp_d);
    check("out_sat", out_sat, exp_s);
    got = out_data;
    if (ready_delay > 0) out_ready = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_d);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    model_emit(exp_d, exp_s);
  endtask

  initial begin
    coef_t  cz, cf;
    longint got;
    longint a, b;
    longint gh [5];
    bit     seen;

    cz = '{0, 0, 0, 0, 0};
    set_coefs(cz);
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    do_reset();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);

    // Pass-through
    do_sample(409600, cz, 0, 0, 0, got);
    check("pt_const", got, 100);

    // Recursion from clean history
    do_reset();
    cf = '{2048, 0, 0, 0, 0};
    do_sample(409600, cf, 0, 0, 0, got);
    check("rec0_const", got, 100);
    do_sample(0, cf, 0, 1, 0, got);
    check("rec1_const", got, -50);

    // Saturation: doubling per sample until clamp
    do_reset();
    cf = '{-8192, 0, 0, 0, 0};
    do_sample(16384000, cf, 0, 0, 0, got);
    check("sat0_const", got, 4000);
    do_sample(0, cf, 0, 0, 0, got);
    check("sat1_const", got, 8000);
    do_sample(0, cf, 0, 0, 0, got);
    check("sat2_const", got, 16000);
    do_sample(0, cf, 0, 0, 0, got);
    check("sat3_const", got, 32000);
    do_sample(0, cf, 0, 0, 0, got);
    check("sat4_const", got, 32767);
    check("sat_count_after_clamp", sat_count, SAT_EN ? 1 : 0);
    check("sat_count_model", sat_count, m_sat_cnt);

    // Backpressure, then confirm history shifted exactly once
    do_reset();
    do_sample(409600, cz, 10, 0, 0, got);
    cf = '{4096, 0, 0, 0, 0};
    do_sample(0, cf, 0, 0, 0, got);
    check("bp_history_const", got, -100);

    // Reset during MAC discards the sample
    do_reset();
    cf = '{2048, 0, 0, 0, 0};
    set_coefs(cf);
    in_data  = 26'(409600);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", seen, 0);
    do_sample(409600, cf, 0, 0, 0, got);
    check("mid_rst_next_const", got, 100);

    // Round trip through an ideal FIR with c0 = 2^SHIFT; magnitudes bounded so b fits 26 bits.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 5; i++) begin
        cf[i] = int'($urandom_range(2000)) - 1000;
        gh[i] = 0;
      end
      for (int n = 0; n < 10; n++) begin
        a = longint'($urandom_range(4000)) - 2000;
        b = a <<< SHIFT;
        for (int i = 0; i < 5; i++) b += longint'(cf[i]) * gh[i];
        do_sample(b, cf, int'($urandom_range(3)), 1'b1, 1'($urandom_range(1)), got);
        check("rt_exact", got, a);
        for (int i = 4; i > 0; i--) gh[i] = gh[i-1];
        gh[0] = a;
      end
      check("rt_sat_count", sat_count, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
